// File: rtl/relu_pkg.sv
// Shared constants for the streaming FP32 activation unit: mode encodings and FP32 field layout.
package relu_pkg;

  localparam logic [1:0] MODE_RELU  = 2'd0;
  localparam logic [1:0] MODE_LEAKY = 2'd1;
  localparam logic [1:0] MODE_CLAMP = 2'd2;

  localparam int unsigned FP_W    = 32;
  localparam int unsigned EXP_MSB = 30;
  localparam int unsigned EXP_LSB = 23;
  localparam logic [7:0]  EXP_MAX = 8'hFF;

  localparam logic [FP_W-1:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [FP_W-1:0] FP_NEG_ZERO = 32'h8000_0000;

endpackage

// File: rtl/relu_stream_lane.sv
// Combinational per-lane activation: ReLU, power-of-two leaky ReLU, or clamped ReLU on raw FP32 bits.
module relu_lane
  import relu_pkg::*;
#(
  parameter int unsigned LEAK_SHIFT = 3
) (
  input  logic [FP_W-1:0] din,
  input  logic [1:0]      mode,
  input  logic [FP_W-1:0] clamp_val,
  output logic [FP_W-1:0] dout
);

  logic       sign;
  logic [7:0] exp_in;

  assign sign   = din[FP_W-1];
  assign exp_in = din[EXP_MSB:EXP_LSB];

  always_comb begin
    dout = din;
    case (mode)
      MODE_LEAKY: begin
        // Negative inf/NaN pass; tiny magnitudes flush to -0 instead of going denormal.
        if (sign && (exp_in != EXP_MAX)) begin
          if (exp_in <= 8'(LEAK_SHIFT)) begin
            dout = FP_NEG_ZERO;
          end else begin
            dout = {sign, exp_in - 8'(LEAK_SHIFT), din[EXP_LSB-1:0]};
          end
        end
      end
      MODE_CLAMP: begin
        // Magnitude compare on raw bits also routes +inf and +NaN to the bound.
        if (sign) begin
          dout = FP_POS_ZERO;
        end else if (din[EXP_MSB:0] > clamp_val[EXP_MSB:0]) begin
          dout = clamp_val;
        end
      end
      default: begin
        if (sign) dout = FP_POS_ZERO;
      end
    endcase
  end

endmodule

// File: rtl/relu_stream.sv
// Two-stage valid/ready FP32 activation pipeline with a saturating count of negative input lanes.
module relu_stream
  import relu_pkg::*;
#(
  parameter int unsigned LANES      = 4,
  parameter int unsigned LEAK_SHIFT = 3,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic [FP_W-1:0]       clamp_val,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [FP_W*LANES-1:0] s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FP_W*LANES-1:0] m_data,
  output logic                  m_last,
  input  logic                  cnt_clr,
  output logic [CNT_W-1:0]      neg_count
);

  localparam int unsigned DW    = FP_W * LANES;
  localparam int unsigned PC_W  = $clog2(LANES + 1);
  localparam int unsigned SUM_W = CNT_W + PC_W;

  logic            s1_valid;
  logic [DW-1:0]   s1_data;
  logic            s1_last;
  logic [1:0]      s1_mode;
  logic [FP_W-1:0] s1_clamp;
  logic [DW-1:0]   lane_out;
  logic            s2_en;
  logic            accept;
  logic [PC_W-1:0] neg_lanes;
  logic [SUM_W-1:0] cnt_sum;
  logic [CNT_W-1:0] cnt_next;

  assign s2_en   = !m_valid || m_ready;
  assign s_ready = !s1_valid || s2_en;
  assign accept  = s_valid && s_ready;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    relu_lane #(.LEAK_SHIFT(LEAK_SHIFT)) u_lane (
      .din      (s1_data[FP_W*g +: FP_W]),
      .mode     (s1_mode),
      .clamp_val(s1_clamp),
      .dout     (lane_out[FP_W*g +: FP_W])
    );
  end

  // Sign popcount of the incoming beat, added with headroom then saturated.
  always_comb begin
    neg_lanes = '0;
    for (int i = 0; i < LANES; i++) begin
      neg_lanes = neg_lanes + PC_W'(s_data[FP_W*i + FP_W - 1]);
    end
    cnt_sum  = SUM_W'(neg_count) + SUM_W'(neg_lanes);
    cnt_next = (|cnt_sum[SUM_W-1:CNT_W]) ? '1 : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_last   <= 1'b0;
      s1_mode   <= MODE_RELU;
      s1_clamp  <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
      neg_count <= '0;
    end else begin
      if (s_ready) begin
        s1_valid <= s_valid;
        if (s_valid) begin
          s1_data  <= s_data;
          s1_last  <= s_last;
          s1_mode  <= mode;
          s1_clamp <= clamp_val;
        end
      end
      // Output stage only advances when empty or drained, so m_* stay frozen under stall.
      if (s2_en) begin
        m_valid <= s1_valid;
        if (s1_valid) begin
          m_data <= lane_out;
          m_last <= s1_last;
        end
      end
      if (cnt_clr) begin
        neg_count <= '0;
      end else if (accept) begin
        neg_count <= cnt_next;
      end
    end
  end

endmodule

// File: tb/tb_relu_stream.sv
// Self-checking bench for relu_stream: directed vector table, counter/reset corners, scoreboarded random traffic.
module tb_relu_stream;

  localparam int unsigned LANES   = 4;
  localparam int unsigned LS      = 3;
  localparam int unsigned CW      = 4;
  localparam int unsigned DW      = 32 * LANES;
  localparam int unsigned CNT_MAX = 15;

  logic          clk;
  logic          reset;
  logic [1:0]    mode;
  logic [31:0]   clamp_val;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          cnt_clr;
  logic [CW-1:0] neg_count;

  relu_stream #(.LANES(LANES), .LEAK_SHIFT(LS), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .mode(mode), .clamp_val(clamp_val),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .cnt_clr(cnt_clr), .neg_count(neg_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]    mode;
    logic [31:0]   clamp;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          last;
    int unsigned   cnt;
  } vec_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  vec_t vecs[6];
  exp_t sb_q[$];
  int unsigned model_cnt;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference lane behaviour expressed on FP32 fields; leaky scaling is an exponent subtraction.
  function automatic logic [31:0] model_lane(input logic [31:0] x, input logic [1:0] md,
                                             input logic [31:0] cv);
    bit          neg = x[31];
    int unsigned ex  = int'(x[30:23]);
    if (md == 2'd1) begin
      if (!neg || ex == 255) return x;
      if (ex <= LS) return 32'h8000_0000;
      return x - (32'(LS) << 23);
    end else if (md == 2'd2) begin
      if (neg) return 32'h0;
      if (int'(x[30:0]) > int'(cv[30:0])) return cv;
      return x;
    end
    return neg ? 32'h0 : x;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v = $urandom;
    case ($urandom_range(0, 7))
      0: v[30:23] = 8'hFF;
      1: v[30:23] = 8'($urandom_range(0, 4));
      2: v[30:0]  = 31'h0;
      default: ;
    endcase
    return v;
  endfunction

  function automatic int unsigned signs(input logic [DW-1:0] d);
    int unsigned n = 0;
    for (int i = 0; i < LANES; i++) n += int'(d[32*i+31]);
    return n;
  endfunction

  task automatic clear_cnt();
    cnt_clr = 1'b1;
    s_valid = 1'b0;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    model_cnt = 0;
  endtask

  // One beat into an idle pipeline with m_ready high: output must appear exactly two cycles later.
  task automatic run_vec(input int idx);
    clear_cnt();
    m_ready   = 1'b1;
    s_valid   = 1'b1;
    s_data    = vecs[idx].din;
    mode      = vecs[idx].mode;
    clamp_val = vecs[idx].clamp;
    s_last    = vecs[idx].last;
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_data  = {$urandom, $urandom, $urandom, $urandom};
    chk($sformatf("vec%0d_lat1_valid", idx), DW'(m_valid), DW'(0));
    @(posedge clk); #1;
    chk($sformatf("vec%0d_lat2_valid", idx), DW'(m_valid), DW'(1));
    chk($sformatf("vec%0d_data", idx), m_data, vecs[idx].dout);
    chk($sformatf("vec%0d_last", idx), DW'(m_last), DW'(vecs[idx].last));
    chk($sformatf("vec%0d_cnt", idx), DW'(neg_count), DW'(vecs[idx].cnt));
    @(posedge clk); #1;
  endtask

  // Scoreboarded traffic; pat=1 gives full-rate input with m_ready pattern 1,0,0,1.
  task automatic run_traffic(input int n, input bit pat, input int budget);
    int     sent = 0;
    int     cyc = 0;
    bit     prev_stall = 0;
    logic [DW-1:0] prev_data = '0;
    logic   prev_last = 1'b0;
    exp_t   e;
    exp_t   got;
    while ((sent < n || sb_q.size() != 0) && cyc < budget) begin
      s_valid = (sent < n) && (pat || $urandom_range(0, 3) != 0);
      for (int i = 0; i < LANES; i++) s_data[32*i +: 32] = rand_fp();
      mode      = 2'($urandom_range(0, 3));
      clamp_val = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
      s_last    = 1'($urandom);
      m_ready   = pat ? (cyc % 4 == 0 || cyc % 4 == 3) : ($urandom_range(0, 3) != 0);
      cnt_clr   = pat ? 1'b0 : ($urandom_range(0, 15) == 0);
      @(negedge clk);
      chk("s_ready", DW'(s_ready), DW'(!(sb_q.size() == 2 && !m_ready)));
      chk("neg_count", DW'(neg_count), DW'(model_cnt));
      if (prev_stall) begin
        chk("stall_valid", DW'(m_valid), DW'(1));
        chk("stall_data", m_data, prev_data);
        chk("stall_last", DW'(m_last), DW'(prev_last));
      end
      if (m_valid && m_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_beat", DW'(1), DW'(0));
        end else begin
          got = sb_q.pop_front();
          chk("out_data", m_data, got.data);
          chk("out_last", DW'(m_last), DW'(got.last));
        end
      end
      if (s_valid && s_ready) begin
        for (int i = 0; i < LANES; i++)
          e.data[32*i +: 32] = model_lane(s_data[32*i +: 32], mode, clamp_val);
        e.last = s_last;
        sb_q.push_back(e);
        sent++;
      end
      if (cnt_clr) model_cnt = 0;
      else if (s_valid && s_ready) model_cnt = (model_cnt + signs(s_data) > CNT_MAX) ?
                                               CNT_MAX : model_cnt + signs(s_data);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= budget) chk("traffic_timeout", DW'(cyc), DW'(0));
    s_valid = 1'b0;
    cnt_clr = 1'b0;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{2'd0, 32'h0, {32'hC0000000, 32'h3F800000, 32'h80000000, 32'h7FC00000},
                {32'h00000000, 32'h3F800000, 32'h00000000, 32'h7FC00000}, 1'b1, 2};
    vecs[1] = '{2'd1, 32'h0, {32'hC1000000, 32'h81000000, 32'hFF800000, 32'h3F800000},
                {32'hBF800000, 32'h80000000, 32'hFF800000, 32'h3F800000}, 1'b0, 3};
    vecs[2] = '{2'd2, 32'h40C00000, {32'h40F00000, 32'h40400000, 32'h7F800000, 32'hC0000000},
                {32'h40C00000, 32'h40400000, 32'h40C00000, 32'h00000000}, 1'b1, 1};
    vecs[3] = '{2'd3, 32'h40C00000, {32'hC0000000, 32'h7FC00000, 32'hFFC00000, 32'h00000001},
                {32'h00000000, 32'h7FC00000, 32'h00000000, 32'h00000001}, 1'b0, 2};
    vecs[4] = '{2'd1, 32'h0, {32'h80000001, 32'h81800000, 32'h82000000, 32'hFFC00001},
                {32'h80000000, 32'h80000000, 32'h80800000, 32'hFFC00001}, 1'b1, 4};
    vecs[5] = '{2'd2, 32'h40C00000, {32'h7FC00000, 32'h40C00000, 32'h80000000, 32'h00000000},
                {32'h40C00000, 32'h40C00000, 32'h00000000, 32'h00000000}, 1'b0, 1};

    reset = 1'b1; mode = 2'd0; clamp_val = 32'h0; s_valid = 1'b0; s_data = '0;
    s_last = 1'b0; m_ready = 1'b1; cnt_clr = 1'b0; model_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", DW'(m_valid), DW'(0));
    chk("rst_m_data", m_data, DW'(0));
    chk("rst_m_last", DW'(m_last), DW'(0));
    chk("rst_neg_count", DW'(neg_count), DW'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("rst_s_ready", DW'(s_ready), DW'(1));
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_vec(i);

    // Saturation with 4-bit counter: 4, 8, 12, then pinned at 15.
    clear_cnt();
    s_valid = 1'b1;
    mode = 2'd0;
    for (int k = 0; k < 5; k++) begin
      s_data = {32'hBF800000, 32'hC0000000, 32'h80000000, 32'hFF800000};
      @(posedge clk); #1;
      chk($sformatf("sat_beat%0d", k), DW'(neg_count),
          DW'((4 * (k + 1) > CNT_MAX) ? CNT_MAX : 4 * (k + 1)));
    end
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sat_hold", DW'(neg_count), DW'(CNT_MAX));

    // Clear wins over a same-cycle accepted negative beat.
    s_valid = 1'b1;
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    cnt_clr = 1'b0;
    chk("clr_priority", DW'(neg_count), DW'(0));
    repeat (3) @(posedge clk);
    #1;

    // Reset with both stages occupied drops both beats.
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = {32'h3F800000, 32'h40000000, 32'hC0000000, 32'h40400000};
    @(posedge clk); #1;
    s_data  = {32'h40800000, 32'h40A00000, 32'hC0400000, 32'h40E00000};
    @(posedge clk); #1;
    s_valid = 1'b0;
    chk("full_s_ready", DW'(s_ready), DW'(0));
    chk("full_m_valid", DW'(m_valid), DW'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_ready = 1'b1;
    chk("midrst_m_valid", DW'(m_valid), DW'(0));
    chk("midrst_cnt", DW'(neg_count), DW'(0));
    chk("midrst_s_ready", DW'(s_ready), DW'(1));
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("no_stale%0d", k), DW'(m_valid), DW'(0));
    end

    clear_cnt();
    sb_q.delete();
    run_traffic(10, 1'b1, 200);
    clear_cnt();
    run_traffic(300, 1'b0, 5000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
